// File: rtl/common_types_pkg.sv
// Shared memory-interface types for the core's ram path.
// ram_state_t is the handshake seen by every ram requester; arb_* types belong to ram_arbiter.
package common_types_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFETCH = 2'd1,
        ARB_DATA   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port ram between instruction fetch (I, read-only) and data (D, load/store).
// A grant covers one whole transaction, from request to RAM_DONE, and adds no latency: the
// winner is picked combinationally in the idle cycle and drives the ram in that same cycle.
// Optional feature: define RAM_ARB_RR_EN for round-robin tie-breaking (default: D beats I).
module ram_arbiter
    import common_types_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                nrst,
    // instruction fetch port
    input  logic                i_ren,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_load,
    output ram_state_t          i_state,
    // data port
    input  logic                d_ren,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_store,
    output logic [DATA_W-1:0]   d_load,
    output ram_state_t          d_state,
    // toward the ram
    output logic                m_ren,
    output logic [DATA_W/8-1:0] m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_store,
    input  logic [DATA_W-1:0]   m_load,
    input  ram_state_t          m_state
);

    arb_state_t state_q, state_d;
    arb_port_t  last_grant;
    arb_port_t  winner;
    arb_port_t  owner;
    logic       have_owner;
    logic       i_req, d_req;

    // On a tie the port that was not granted last wins.
    function automatic arb_port_t pick(logic i_rq, logic d_rq, arb_port_t last);
        if (i_rq && d_rq) begin
            return (last == ARB_PORT_D) ? ARB_PORT_I : ARB_PORT_D;
        end
        return d_rq ? ARB_PORT_D : ARB_PORT_I;
    endfunction

    assign i_req  = i_ren;
    assign d_req  = d_ren | (|d_wen);
    assign winner = pick(i_req, d_req, last_grant);

`ifdef RAM_ARB_RR_EN
    arb_port_t last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    // No history kept: pretending I was always granted last makes every tie go to D.
    assign last_grant = ARB_PORT_I;
`endif

    // Who owns the ram this cycle: the fresh winner when idle, else the granted port.
    always_comb begin
        have_owner = 1'b0;
        owner      = ARB_PORT_D;
        unique case (state_q)
            ARB_IDLE: begin
                have_owner = i_req | d_req;
                owner      = winner;
            end
            ARB_IFETCH: begin
                have_owner = 1'b1;
                owner      = ARB_PORT_I;
            end
            ARB_DATA: begin
                have_owner = 1'b1;
                owner      = ARB_PORT_D;
            end
            default: ;
        endcase
    end

    // Route the owner to the ram and the ram's answer back to the owner only.
    always_comb begin
        m_ren   = 1'b0;
        m_wen   = '0;
        m_addr  = '0;
        m_store = '0;
        i_load  = '0;
        d_load  = '0;
        i_state = i_req ? RAM_WAIT : RAM_IDLE;
        d_state = d_req ? RAM_WAIT : RAM_IDLE;
        if (!nrst) begin
            // Outputs follow reset immediately, even with requests still asserted.
            i_state = RAM_IDLE;
            d_state = RAM_IDLE;
        end else if (have_owner) begin
            if (owner == ARB_PORT_I) begin
                m_ren   = i_ren;
                m_addr  = i_addr;
                i_state = m_state;
                i_load  = m_load;
            end else begin
                m_ren   = d_ren;
                m_wen   = d_wen;
                m_addr  = d_addr;
                m_store = d_store;
                d_state = m_state;
                d_load  = m_load;
            end
        end
    end

    // Grant on a request when idle; release on DONE or if the owner abandons its request.
    always_comb begin
        state_d = state_q;
`ifdef RAM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    state_d = (winner == ARB_PORT_D) ? ARB_DATA : ARB_IFETCH;
`ifdef RAM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                end
            end
            ARB_IFETCH: begin
                if (m_state == RAM_DONE || !i_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (m_state == RAM_DONE || !d_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef RAM_ARB_RR_EN
    // Remember the most recent grant for the round-robin tie-break.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant_q <= ARB_PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

`ifndef SYNTHESIS
    // An owner dropping its request mid-transaction may leave a partial write behind.
    always_ff @(posedge clk) begin
        if (nrst && ((state_q == ARB_IFETCH && !i_req) || (state_q == ARB_DATA && !d_req))) begin
            $error("ram_arbiter: owner dropped its request before RAM_DONE");
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a LAT=0 ram model (a lone access is DONE on its
// 2nd cycle). Tie-break expectations follow RAM_ARB_RR_EN when the bench is built with it.
module tb_ram_arbiter;
    import common_types_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_load;
    ram_state_t  i_state;
    logic        d_ren;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic [31:0] d_load;
    ram_state_t  d_state;
    logic        m_ren;
    logic [3:0]  m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    logic [31:0] m_load;
    ram_state_t  m_state;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .nrst(nrst),
        .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_state(i_state),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
        .d_load(d_load), .d_state(d_state),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_store(m_store),
        .m_load(m_load), .m_state(m_state)
    );

    function automatic logic [31:0] init_word(int k);
        return 32'hC0DE0000 ^ (32'(k) * 32'h00010101);
    endfunction

    // ---------------- ram model, LAT=0 ----------------
    logic [31:0] mem [MW];
    logic        mem_init;
    logic        cnt_q;
    logic        m_req;
    assign m_req = m_ren | (|m_wen);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= 1'b0;
        else       cnt_q <= m_req && !cnt_q;
    end

    always_comb begin
        m_state = RAM_IDLE;
        m_load  = '0;
        if (nrst && m_req) begin
            if (cnt_q) begin
                m_state = RAM_DONE;
                m_load  = mem[m_addr[9:2]];
            end else begin
                m_state = RAM_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < MW; k++) mem[k] <= init_word(k);
        end else if (nrst && m_state == RAM_DONE) begin
            for (int b = 0; b < 4; b++) begin
                if (m_wen[b]) mem[m_addr[9:2]][8*b +: 8] <= m_store[8*b +: 8];
            end
        end
    end

    // ---------------- reference memory and checking ----------------
    logic [31:0] ref_mem [MW];
    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic ref_write(logic [31:0] a, logic [3:0] w, logic [31:0] v);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) ref_mem[a[9:2]][8*b +: 8] = v[8*b +: 8];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ren = 1'b0; i_addr = '0;
        d_ren = 1'b0; d_wen = '0; d_addr = '0; d_store = '0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        idle_inputs();
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_m_bus"}, 72'({m_ren, m_wen, m_addr, m_store}), 72'(0));
        check({tag, "_states"}, 72'({i_state, d_state}), 72'({RAM_IDLE, RAM_IDLE}));
        check({tag, "_loads"}, 72'({i_load, d_load}), 72'(0));
    endtask

    typedef struct {
        logic        i_ren;
        logic [31:0] i_addr;
        logic        d_ren;
        logic [3:0]  d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_store;
        int          exp_i_done;  // cycle of I's DONE, -1 when I idle
        int          exp_d_done;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    // Random-phase model state
    logic        i_act, d_act, busy, own_d, last_d, done;
    int          gcyc;
    ram_state_t  exp_i, exp_d;
    logic [31:0] exp_il, exp_dl;
    logic [68:0] exp_bus;
    // Directed-test scratch
    int          idone, ddone, ndone, d_at_i;
    logic [31:0] iload;
    int          tie_i, tie_d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RAM_ARB_RR_EN
        tie_i = 1; tie_d = 3;
`else
        tie_i = 3; tie_d = 1;
`endif
        //         i_ren i_addr      d_ren d_wen   d_addr      d_store       exp_i exp_d
        vt[0] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h000, 32'h0,        1,    -1};
        vt[1] = '{1'b0, 32'h000, 1'b1, 4'h0, 32'h040, 32'h0,        -1,   1};
        vt[2] = '{1'b0, 32'h000, 1'b0, 4'hF, 32'h080, 32'h12345678, -1,   1};
        vt[3] = '{1'b1, 32'h0C0, 1'b1, 4'h0, 32'h044, 32'h0,        tie_i, tie_d};
        vt[4] = '{1'b1, 32'h100, 1'b0, 4'h2, 32'h204, 32'h0000AB00, tie_i, tie_d};
        vt[5] = '{1'b1, 32'h204, 1'b0, 4'h0, 32'h000, 32'h0,        1,    -1};

        for (int k = 0; k < MW; k++) ref_mem[k] = init_word(k);
        nrst = 1'b0;
        idle_inputs();
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;

        // Reset state, with both ports requesting while reset is held.
        i_ren = 1'b1; i_addr = 32'h10; d_wen = 4'hF; d_addr = 32'h20; d_store = 32'hFFFF_FFFF;
        #3;
        check_reset_outputs("reset");
        do_reset();

        // ---- table-driven transactions, reset before each ----
        for (int v = 0; v < NV; v++) begin
            do_reset();
            idone = -1; ddone = -1; iload = '0;
            for (int c = 0; c < 8; c++) begin
                i_ren   = vt[v].i_ren && idone < 0;
                i_addr  = vt[v].i_addr;
                d_ren   = vt[v].d_ren && ddone < 0;
                d_wen   = (ddone < 0) ? vt[v].d_wen : 4'h0;
                d_addr  = vt[v].d_addr;
                d_store = vt[v].d_store;
                #3;
                if (i_state == RAM_DONE && idone < 0) begin
                    idone = c;
                    iload = i_load;
                end
                if (d_state == RAM_DONE && ddone < 0) ddone = c;
                tick();
            end
            idle_inputs();
            check($sformatf("vec%0d_i_done_cycle", v), 72'(idone), 72'(vt[v].exp_i_done));
            check($sformatf("vec%0d_d_done_cycle", v), 72'(ddone), 72'(vt[v].exp_d_done));
            if (vt[v].i_ren) begin
                check($sformatf("vec%0d_i_load", v), 72'(iload),
                      72'(ref_mem[vt[v].i_addr[9:2]]));
            end
            if (|vt[v].d_wen) ref_write(vt[v].d_addr, vt[v].d_wen, vt[v].d_store);
        end

        // ---- T1: lone fetch, cycle by cycle ----
        do_reset();
        i_ren = 1'b1; i_addr = 32'h100;
        #3;
        check("t1_c0_m_bus", 72'({m_ren, m_wen, m_addr}), 72'({1'b1, 4'h0, 32'h100}));
        check("t1_c0_states", 72'({i_state, d_state}), 72'({RAM_WAIT, RAM_IDLE}));
        tick();
        #3;
        check("t1_c1_i_state", 72'(i_state), 72'(RAM_DONE));
        check("t1_c1_i_load", 72'(i_load), 72'(ref_mem[8'h40]));
        tick();
        i_ren = 1'b0;
        d_ren = 1'b1; d_addr = 32'h3F0;
        #3;
        // Back in idle: a new D request is routed in the very same cycle.
        check("t1_c2_i_state", 72'(i_state), 72'(RAM_IDLE));
        check("t1_c2_d_grant", 72'({d_state, m_ren, m_addr}), 72'({RAM_WAIT, 1'b1, 32'h3F0}));
        tick();
        #3;
        check("t1_c3_d_load", 72'({d_state, d_load}), 72'({RAM_DONE, ref_mem[8'hFC]}));
        tick();
        idle_inputs();

        // ---- T5: D back-to-back loads while I holds its request ----
        do_reset();
        ndone = 0; idone = -1; d_at_i = -1;
        for (int c = 0; c < 16; c++) begin
            i_ren  = (c >= 1) && idone < 0;
            i_addr = 32'h10;
            d_ren  = ndone < 4;
            d_addr = 32'h20 + 32'(ndone) * 4;
            #3;
            if (d_state == RAM_DONE) ndone++;
            if (i_state == RAM_DONE && idone < 0) begin
                idone  = c;
                d_at_i = ndone;
            end
            tick();
        end
        idle_inputs();
`ifdef RAM_ARB_RR_EN
        check("t5_i_done_cycle", 72'(idone), 72'(3));
        check("t5_d_done_before_i", 72'(d_at_i), 72'(1));
`else
        check("t5_i_done_cycle", 72'(idone), 72'(9));
        check("t5_d_done_before_i", 72'(d_at_i), 72'(4));
`endif
        check("t5_d_total", 72'(ndone), 72'(4));

        // ---- T6: reset in the middle of a D write ----
        do_reset();
        d_wen = 4'hF; d_addr = 32'h300; d_store = 32'hDEADBEEF;
        #3;
        check("t6_c0_d_state", 72'(d_state), 72'(RAM_WAIT));
        tick();
        nrst = 1'b0;
        #1;
        check_reset_outputs("t6_mid");
        tick();
        idle_inputs();
        tick();
        nrst = 1'b1;
        i_ren = 1'b1; i_addr = 32'h300;
        #3;
        check("t6_after_no_stale_done", 72'(i_state), 72'(RAM_WAIT));
        tick();
        #3;
        check("t6_after_done", 72'(i_state), 72'(RAM_DONE));
        check("t6_write_aborted", 72'(i_load), 72'(ref_mem[8'hC0]));
        tick();
        idle_inputs();

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        busy = 1'b0; last_d = 1'b1; i_act = 1'b0; d_act = 1'b0; own_d = 1'b0; gcyc = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act  = 1'b1;
                i_addr = 32'($urandom_range(0, MW - 1)) << 2;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act  = 1'b1;
                d_addr = 32'($urandom_range(0, MW - 1)) << 2;
                d_store = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    d_ren = 1'b0;
                    d_wen = 4'($urandom_range(1, 15));
                end else begin
                    d_ren = 1'b1;
                    d_wen = 4'h0;
                end
            end
            i_ren = i_act;
            if (!d_act) begin
                d_ren = 1'b0;
                d_wen = 4'h0;
            end
            #3;
            // Free arbiter grants one pending port; a grant lasts exactly two cycles at LAT=0.
            if (!busy && (i_act || d_act)) begin
                if (i_act && d_act) begin
`ifdef RAM_ARB_RR_EN
                    own_d = !last_d;
`else
                    own_d = 1'b1;
`endif
                end else begin
                    own_d = d_act;
                end
                last_d = own_d;
                busy   = 1'b1;
                gcyc   = n;
            end
            done    = busy && (n != gcyc);
            exp_i   = i_act ? RAM_WAIT : RAM_IDLE;
            exp_d   = d_act ? RAM_WAIT : RAM_IDLE;
            exp_il  = '0;
            exp_dl  = '0;
            exp_bus = '0;
            if (busy) begin
                if (own_d) begin
                    exp_d   = done ? RAM_DONE : RAM_WAIT;
                    exp_dl  = done ? ref_mem[d_addr[9:2]] : 32'h0;
                    exp_bus = {d_ren, d_wen, d_addr, d_store};
                end else begin
                    exp_i   = done ? RAM_DONE : RAM_WAIT;
                    exp_il  = done ? ref_mem[i_addr[9:2]] : 32'h0;
                    exp_bus = {1'b1, 4'h0, i_addr, 32'h0};
                end
            end
            check($sformatf("rnd%0d_i_state", n), 72'(i_state), 72'(exp_i));
            check($sformatf("rnd%0d_d_state", n), 72'(d_state), 72'(exp_d));
            check($sformatf("rnd%0d_loads", n), 72'({i_load, d_load}), 72'({exp_il, exp_dl}));
            check($sformatf("rnd%0d_m_bus", n), 72'({m_ren, m_wen, m_addr, m_store}),
                  72'(exp_bus));
            if (done) begin
                busy = 1'b0;
                if (own_d) ref_write(d_addr, d_wen, d_store);
            end
            if (i_state == RAM_DONE) i_act = 1'b0;
            if (d_state == RAM_DONE) d_act = 1'b0;
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
